// File: rtl/wb_guard_pkg.sv
// Shared types and constants for the Wishbone bus guard slice.
package wb_guard_pkg;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;

  localparam logic [DAT_W-1:0] ERR_DATA_DEF = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Saturating 16-bit statistics step; a clear coinciding with an event leaves a count of 1.
  function automatic logic [15:0] sat_step(input logic [15:0] cur,
                                           input logic        inc,
                                           input logic        clr);
    logic [15:0] base;
    base = clr ? '0 : cur;
    if (inc && (base != '1)) begin
      base = base + 16'd1;
    end
    return base;
  endfunction

endpackage

// File: rtl/wb_guard_timer.sv
// Timeout counter for the bus guard: cleared while idle, counts FWD cycles, flags TIMEOUT-1.
module wb_guard_timer #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    tc = (cnt == CW'(TIMEOUT - 1));
  end

endmodule

// File: rtl/wb_bus_guard.sv
// Registered Wishbone slice with downstream timeout, sticky irq and error-address capture.
// Optional statistics counters are built when WB_GUARD_STATS_EN is defined.
module wb_bus_guard
  import wb_guard_pkg::*;
#(
  parameter int unsigned      TIMEOUT  = 64,
  parameter logic [DAT_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [SEL_W-1:0] wbs_sel_i,
  input  logic [ADR_W-1:0] wbs_adr_i,
  input  logic [DAT_W-1:0] wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [DAT_W-1:0] wbs_dat_o,
  output logic             m_cyc_o,
  output logic             m_stb_o,
  output logic             m_we_o,
  output logic [SEL_W-1:0] m_sel_o,
  output logic [ADR_W-1:0] m_adr_o,
  output logic [DAT_W-1:0] m_dat_o,
  input  logic             m_ack_i,
  input  logic [DAT_W-1:0] m_dat_i,
  output logic             irq_o,
  input  logic             irq_clr_i,
  output logic [ADR_W-1:0] err_adr_o
`ifdef WB_GUARD_STATS_EN
  ,
  output logic [15:0]      txn_cnt_o,
  output logic [15:0]      tmo_cnt_o
`endif
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_t state;
  logic   tmr_clr;
  logic   tmr_inc;
  logic   tmr_tc;

  always_comb begin
    tmr_clr = (state == IDLE);
    tmr_inc = (state == FWD);
  end

  wb_guard_timer #(
    .TIMEOUT(TIMEOUT),
    .CW     (CW)
  ) u_timer (
    .clk  (wb_clk_i),
    .rst_n(wb_rst_ni),
    .clr  (tmr_clr),
    .inc  (tmr_inc),
    .tc   (tmr_tc)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state     <= IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      m_cyc_o   <= 1'b0;
      m_stb_o   <= 1'b0;
      m_we_o    <= 1'b0;
      m_sel_o   <= '0;
      m_adr_o   <= '0;
      m_dat_o   <= '0;
      irq_o     <= 1'b0;
      err_adr_o <= '0;
    end else begin
      // Clear first so that a timeout in the same cycle overrides it.
      if (irq_clr_i) begin
        irq_o <= 1'b0;
      end
      case (state)
        IDLE: begin
          wbs_ack_o <= 1'b0;
          if (wbs_cyc_i && wbs_stb_i) begin
            m_adr_o <= wbs_adr_i;
            m_dat_o <= wbs_dat_i;
            m_we_o  <= wbs_we_i;
            m_sel_o <= wbs_sel_i;
            m_cyc_o <= 1'b1;
            m_stb_o <= 1'b1;
            state   <= FWD;
          end
        end
        FWD: begin
          if (!wbs_cyc_i) begin
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            state   <= IDLE;
          end else if (m_ack_i) begin
            wbs_dat_o <= m_dat_i;
            wbs_ack_o <= 1'b1;
            m_cyc_o   <= 1'b0;
            m_stb_o   <= 1'b0;
            state     <= RESP;
          end else if (tmr_tc) begin
            wbs_dat_o <= ERR_DATA;
            wbs_ack_o <= 1'b1;
            irq_o     <= 1'b1;
            err_adr_o <= m_adr_o;
            m_cyc_o   <= 1'b0;
            m_stb_o   <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: begin
          wbs_ack_o <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          wbs_ack_o <= 1'b0;
          m_cyc_o   <= 1'b0;
          m_stb_o   <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef WB_GUARD_STATS_EN
  logic resp_entry;
  logic tmo_hit;

  always_comb begin
    resp_entry = (state == FWD) && wbs_cyc_i && (m_ack_i || tmr_tc);
    tmo_hit    = (state == FWD) && wbs_cyc_i && !m_ack_i && tmr_tc;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      txn_cnt_o <= '0;
      tmo_cnt_o <= '0;
    end else begin
      txn_cnt_o <= sat_step(txn_cnt_o, resp_entry, irq_clr_i);
      tmo_cnt_o <= sat_step(tmo_cnt_o, tmo_hit, irq_clr_i);
    end
  end
`endif

endmodule
